// File: rtl/result_checker_if.sv
// result_checker_if: Avalon-MM write-only bus between the result checker and memory.
interface result_checker_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH/8-1:0] mem_byteenable;
  logic                    mem_write;
  logic [DATA_WIDTH-1:0]   mem_writedata;
  logic                    mem_waitrequest;
  modport master(output mem_address, mem_byteenable, mem_write, mem_writedata, input mem_waitrequest);
  modport slave(input mem_address, mem_byteenable, mem_write, mem_writedata, output mem_waitrequest);
endinterface

// File: rtl/result_checker.sv
// result_checker: compares measured results with expected entries and writes packed records to memory.
// Define RESULT_CHECKER_FAILCNT_EN to add the saturating fail_count output.
module result_checker #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH = 24,
  parameter int ORV_WIDTH = 8,
  parameter int SCC_WIDTH = 5,
  parameter int SCD_WIDTH = 24,
  parameter int CNT_WIDTH = 16,
  localparam int CHF_WIDTH = RTF_WIDTH + ADDR_WIDTH + ORV_WIDTH,
  localparam int NWORDS = (RTF_WIDTH + 8 + DATA_WIDTH - 1) / DATA_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  result_checker_if.master     mem,
  input  logic [RTF_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
  input  logic [CHF_WIDTH-1:0] cfifo_data,
  output logic                 cfifo_rdreq,
  input  logic                 cfifo_rdempty,
  input  logic [SCC_WIDTH-1:0] sc_cmd,
  input  logic [SCD_WIDTH-1:0] sc_data,
  output logic                 sc_ready
`ifdef RESULT_CHECKER_FAILCNT_EN
  , output logic [CNT_WIDTH-1:0] fail_count
`endif
);
  localparam int PW = NWORDS * DATA_WIDTH;
  localparam int PAD = PW - RTF_WIDTH - 8;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, RD_FIFOS, CMP, WRITEBACK} state_t;
  state_t state, state_n;
  logic [RTF_WIDTH-1:0]  res_q, exp_q, res_m, mask;
  logic [ADDR_WIDTH-1:0] chk_addr, addr;
  logic [5:0]            orv_q;
  logic [IW-1:0]         idx;
  logic                  fail, fail_n, accept, last;
  logic [PW-1:0]         p_vec, p_sh;
  assign fail_n = (exp_q & mask) != (res_q & mask);
  assign accept = mem.mem_write && !mem.mem_waitrequest;
  assign last = idx == IW'(NWORDS - 1);
  // record is left-aligned so the first word on the bus always carries the result MSBs
  assign p_vec = PW'({res_m, 1'b1, orv_q, fail}) << PAD;
  assign p_sh = p_vec << (32'(idx) * DATA_WIDTH);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = (!rfifo_rdempty && !cfifo_rdempty) ? RD_FIFOS : IDLE;
      RD_FIFOS:  state_n = CMP;
      CMP:       state_n = WRITEBACK;
      WRITEBACK: state_n = (accept && last) ? IDLE : WRITEBACK;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    rfifo_rdreq = state == RD_FIFOS;
    cfifo_rdreq = state == RD_FIFOS;
    mem.mem_write = state == WRITEBACK;
    mem.mem_address = addr;
    mem.mem_byteenable = '1;
    mem.mem_writedata = p_sh[PW-1 -: DATA_WIDTH];
    sc_ready = (state == IDLE) && rfifo_rdempty && cfifo_rdempty;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      res_q <= '0;
      exp_q <= '0;
      res_m <= '0;
      mask <= '1;
      chk_addr <= '0;
      addr <= '0;
      orv_q <= '0;
      idx <= '0;
      fail <= 1'b0;
    end else begin
      if (sc_cmd == CMD_BITMASK) mask <= sc_data[RTF_WIDTH-1:0];
      if (state == RD_FIFOS) begin
        res_q <= rfifo_data;
        exp_q <= cfifo_data[CHF_WIDTH-1 -: RTF_WIDTH];
        chk_addr <= cfifo_data[ORV_WIDTH +: ADDR_WIDTH];
        orv_q <= cfifo_data[5:0];
      end
      if (state == CMP) begin
        addr <= chk_addr;
        idx <= '0;
        fail <= fail_n;
        res_m <= res_q & mask;
      end else if (accept) begin
        addr <= addr + 1'b1;
        idx <= idx + 1'b1;
      end
    end
`ifdef RESULT_CHECKER_FAILCNT_EN
  localparam logic [SCC_WIDTH-1:0] CMD_CLRCNT = SCC_WIDTH'(2);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) fail_count <= '0;
    else if (sc_cmd == CMD_CLRCNT) fail_count <= '0;
    else if (state == CMP && fail_n && !(&fail_count)) fail_count <= fail_count + 1'b1;
`endif
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: table vectors, hand-written corner sequences and randomized records against a packing model.
module tb_result_checker;
  localparam int AW = 20, DW = 16, RW = 24, OW = 8, CW = 2;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  result_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem();
  logic [RW-1:0]       rfifo_data;
  logic                rfifo_rdreq, rfifo_rdempty, cfifo_rdreq, cfifo_rdempty, sc_ready;
  logic [RW+AW+OW-1:0] cfifo_data;
  logic [4:0]          sc_cmd;
  logic [23:0]         sc_data;
`ifdef RESULT_CHECKER_FAILCNT_EN
  logic [CW-1:0]       fail_count;
`endif
  result_checker #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .mem(mem),
    .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready)
`ifdef RESULT_CHECKER_FAILCNT_EN
    , .fail_count(fail_count)
`endif
  );
  int checks = 0, errors = 0;
  logic [RW-1:0]       rq[$];
  logic [RW+AW+OW-1:0] cq[$];
  logic [AW+DW-1:0]    wq[$], eq[$];
  logic                pr, pc, acc;
  logic [AW+DW-1:0]    wa;
  bit                  wr_rand = 0;
  typedef struct {
    logic [23:0] res, exp, mask;
    logic [19:0] addr;
    logic [7:0]  orv;
    logic [15:0] w0, w1;
  } vec_t;
  vec_t tbl[6];
  function automatic void drive_fifos();
    rfifo_rdempty = rq.size() == 0;
    rfifo_data = rq.size() != 0 ? rq[0] : '0;
    cfifo_rdempty = cq.size() == 0;
    cfifo_data = cq.size() != 0 ? cq[0] : '0;
  endfunction
  // show-ahead FIFOs, bus monitor and random stall source, all updated just after the edge
  always @(posedge clock) begin
    pr = rfifo_rdreq;
    pc = cfifo_rdreq;
    acc = mem.mem_write && !mem.mem_waitrequest;
    wa = {mem.mem_address, mem.mem_writedata};
    #1;
    if (pr || pc) begin
      checks++;
      if (pr !== pc) begin errors++; $display("FAIL rdreq_pair rfifo=%b cfifo=%b", pr, pc); end
    end
    if (pr && rq.size() != 0) void'(rq.pop_front());
    if (pc && cq.size() != 0) void'(cq.pop_front());
    if (acc) wq.push_back(wa);
    if (wr_rand) mem.mem_waitrequest = $urandom_range(3) == 0;
    drive_fifos();
  end
  function automatic logic [31:0] pack(logic [23:0] res, logic [23:0] exp, logic [23:0] m, logic [7:0] orv);
    logic f = ((res ^ exp) & m) != 0;
    return (32'(res & m) << 8) | 32'h80 | (32'(orv & 8'h3F) << 1) | 32'(f);
  endfunction
  task automatic expect_rec(logic [23:0] res, logic [23:0] exp, logic [23:0] m, logic [19:0] a, logic [7:0] orv);
    logic [31:0] p = pack(res, exp, m, orv);
    eq.push_back({a, p[31:16]});
    eq.push_back({AW'(a + 20'd1), p[15:0]});
  endtask
  task automatic push(bit r, bit c, logic [23:0] res, logic [23:0] exp, logic [19:0] a, logic [7:0] orv);
    if (r) rq.push_back(res);
    if (c) cq.push_back({exp, a, orv});
    drive_fifos();
  endtask
  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s got %0h want %0h", nm, got, want); end
  endtask
  task automatic send_cmd(logic [4:0] c, logic [23:0] d);
    @(negedge clock);
    sc_cmd = c;
    sc_data = d;
    @(negedge clock);
    sc_cmd = 5'd0;
  endtask
  task automatic wait_done(int n, string nm);
    int k = 0;
    do begin @(negedge clock); k++; end
    while (!(wq.size() >= n && sc_ready && rq.size() == 0 && cq.size() == 0) && k < 600);
    checks++;
    if (k >= 600) begin errors++; $display("FAIL %s timeout writes %0d want %0d", nm, wq.size(), n); end
  endtask
  task automatic wait_write(string nm);
    int k = 0;
    while (!mem.mem_write && k < 50) begin @(negedge clock); k++; end
    checks++;
    if (k >= 50) begin errors++; $display("FAIL %s no write strobe got 0 want 1", nm); end
  endtask
  task automatic cmp_writes(string nm);
    chk({nm, "_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== eq[i]) begin errors++; $display("FAIL %s word %0d got %h want %h", nm, i, wq[i], eq[i]); end
    end
    wq.delete();
    eq.delete();
  endtask
  initial begin
    logic [35:0] held;
    tbl[0] = '{24'hABCDEF, 24'hABCDEF, 24'hFFFFFF, 20'h00010, 8'h05, 16'hABCD, 16'hEF8A};
    tbl[1] = '{24'hABCDEF, 24'hABCDEE, 24'hFFFFFF, 20'h00010, 8'h05, 16'hABCD, 16'hEF8B};
    tbl[2] = '{24'h1234AA, 24'h123455, 24'hFFFF00, 20'h00010, 8'h05, 16'h1234, 16'h008A};
    tbl[3] = '{24'h000001, 24'h000001, 24'hFFFFFF, 20'hFFFFF, 8'h3F, 16'h0000, 16'h01FE};
    tbl[4] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 20'h00123, 8'hC0, 16'hFFFF, 16'hFF81};
    tbl[5] = '{24'h123456, 24'h654321, 24'h000000, 20'h00200, 8'h2A, 16'h0000, 16'h00D4};
    sc_cmd = 5'd0;
    sc_data = '0;
    mem.mem_waitrequest = 1'b0;
    drive_fifos();
    repeat (3) @(negedge clock);
    chk("rst_write", 64'(mem.mem_write), 64'd0);
    chk("rst_rdreq", 64'({rfifo_rdreq, cfifo_rdreq}), 64'd0);
    chk("rst_addr", 64'(mem.mem_address), 64'd0);
    chk("rst_ready", 64'(sc_ready), 64'd1);
    chk("rst_byteen", 64'(mem.mem_byteenable), 64'h3);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_cmd(5'd1, tbl[i].mask);
      push(1, 1, tbl[i].res, tbl[i].exp, tbl[i].addr, tbl[i].orv);
      eq.push_back({tbl[i].addr, tbl[i].w0});
      eq.push_back({AW'(tbl[i].addr + 20'd1), tbl[i].w1});
      wait_done(2, $sformatf("vec%0d", i));
      cmp_writes($sformatf("vec%0d", i));
    end
    send_cmd(5'd1, 24'hFFFFFF);
    push(1, 0, 24'h00BEEF, 24'h0, 20'h0, 8'h0);
    repeat (6) @(negedge clock);
    chk("one_empty_hold", 64'(rq.size()), 64'd1);
    chk("one_empty_ready", 64'(sc_ready), 64'd0);
    chk("one_empty_write", 64'(mem.mem_write), 64'd0);
    push(0, 1, 24'h0, 24'h00BEEF, 20'h00400, 8'h11);
    expect_rec(24'h00BEEF, 24'h00BEEF, 24'hFFFFFF, 20'h00400, 8'h11);
    wait_done(2, "one_empty");
    cmp_writes("one_empty");
    mem.mem_waitrequest = 1'b1;
    push(1, 1, 24'hABCDEF, 24'hABCDEF, 20'h00010, 8'h05);
    expect_rec(24'hABCDEF, 24'hABCDEF, 24'hFFFFFF, 20'h00010, 8'h05);
    wait_write("stall");
    held = {mem.mem_address, mem.mem_writedata};
    repeat (3) begin
      @(negedge clock);
      chk("stall_hold", 64'({mem.mem_address, mem.mem_writedata}), 64'(held));
      chk("stall_write", 64'(mem.mem_write), 64'd1);
    end
    chk("stall_no_accept", 64'(wq.size()), 64'd0);
    mem.mem_waitrequest = 1'b0;
    wait_done(2, "stall");
    repeat (4) @(negedge clock);
    cmp_writes("stall");
    chk("stall_ready", 64'(sc_ready), 64'd1);
    chk("stall_idle", 64'(mem.mem_write), 64'd0);
    mem.mem_waitrequest = 1'b1;
    push(1, 1, 24'h777777, 24'h777777, 20'h00500, 8'h01);
    wait_write("abort");
    reset_n = 1'b0;
    #1;
    chk("abort_async_write", 64'(mem.mem_write), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    mem.mem_waitrequest = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_no_words", 64'(wq.size()), 64'd0);
    chk("abort_ready", 64'(sc_ready), 64'd1);
    chk("abort_addr", 64'(mem.mem_address), 64'd0);
`ifdef RESULT_CHECKER_FAILCNT_EN
    send_cmd(5'd2, 24'h0);
    chk("cnt_clear0", 64'(fail_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      push(1, 1, 24'h000001, 24'h000000, 20'(i * 2), 8'h00);
      expect_rec(24'h000001, 24'h000000, 24'hFFFFFF, 20'(i * 2), 8'h00);
    end
    wait_done(10, "cnt");
    cmp_writes("cnt");
    chk("cnt_saturate", 64'(fail_count), 64'd3);
    send_cmd(5'd2, 24'h0);
    chk("cnt_clear", 64'(fail_count), 64'd0);
`endif
    wr_rand = 1;
    for (int b = 0; b < 40; b++) begin
      logic [23:0] m = $urandom_range(2) == 0 ? 24'($urandom) : 24'hFFFFFF;
      int n = $urandom_range(1, 4);
      send_cmd(5'd1, m);
      for (int j = 0; j < n; j++) begin
        logic [23:0] res = 24'($urandom);
        logic [23:0] exp = $urandom_range(1) ? res : res ^ (24'd1 << $urandom_range(23));
        logic [19:0] a = $urandom_range(4) == 0 ? 20'hFFFFF : 20'($urandom);
        logic [7:0]  o = 8'($urandom);
        push(1, 1, res, exp, a, o);
        expect_rec(res, exp, m, a, o);
      end
      wait_done(2 * n, "rand");
      cmp_writes($sformatf("rand%0d", b));
    end
    wr_rand = 0;
    mem.mem_waitrequest = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
